// File: rtl/ram_wait_ctrl_pkg.sv
// Shared FSM state type, default geometry and helpers for the wait-state RAM controller.
package ram_wait_ctrl_pkg;

    localparam int DEFAULT_WAIT_CYCLES = 2;
    localparam int DEFAULT_ADDR_W      = 10;
    localparam int DEFAULT_DATA_W      = 10;

    // Wait counter must hold the largest legal WAIT_CYCLES value (15).
    localparam int CNT_W  = 4;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ram_wait_ctrl_ram_array.sv
// Synchronous single-port storage, 2^ADDR_W x DATA_W, write-enable, no reset.
module ram_array #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 10
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Read data only moves on an enabled read, so it holds across writes and idle cycles.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_wait_ctrl.sv
// Cache-side RAM controller inserting WAIT_CYCLES wait states per access.
// Optional macro RAM_WAIT_CTRL_STATS_EN adds saturating rd_count/wr_count outputs.
module ram_wait_ctrl
    import ram_wait_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_rw,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              busy
`ifdef RAM_WAIT_CTRL_STATS_EN
    ,
    output logic [STAT_W-1:0] rd_count,
    output logic [STAT_W-1:0] wr_count
`endif
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              rd_valid_q, rd_valid_d;

    logic              ram_en;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        rd_valid_d = rd_valid_q;
        ready_d    = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    rw_d    = mem_rw;
                    cnt_d   = WAIT_LOAD;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    ram_en  = 1'b1;
                    ram_we  = rw_q;
                    ready_d = 1'b1;
                    state_d = ST_DONE;
                    if (!rw_q) begin
                        rd_valid_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rw_q       <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    ram_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    // The array has no reset, so read data reads as zero until the first read since reset completes.
    assign mem_rdata = rd_valid_q ? ram_rdata : '0;
    assign mem_ready = ready_q;
    assign busy      = busy_q;

`ifdef RAM_WAIT_CTRL_STATS_EN
    logic [STAT_W-1:0] rd_count_q, rd_count_d;
    logic [STAT_W-1:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (ram_en && !ram_we) begin
            rd_count_d = sat_inc(rd_count_q);
        end
        if (ram_en && ram_we) begin
            wr_count_d = sat_inc(wr_count_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_ram_wait_ctrl.sv
// Self-checking bench for ram_wait_ctrl: three instances (WAIT_CYCLES 2, 0, 15) against a memory/latency model.
module tb_ram_wait_ctrl;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_v   [3];
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata_v [3];
    logic              ready_v [3];
    logic              busy_v  [3];
`ifdef RAM_WAIT_CTRL_STATS_EN
    logic [15:0]       rd_cnt_v [3];
    logic [15:0]       wr_cnt_v [3];
`endif

    logic [DATA_W-1:0] model_mem   [3][1024];
    bit                model_valid [3][1024];
    logic [DATA_W-1:0] model_rd    [3];
    int                model_rdc   [3];
    int                model_wrc   [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_wait_ctrl #(.WAIT_CYCLES(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_w2 (
        .clk(clk), .rst(rst), .mem_req(req_v[0]), .mem_rw(rw), .mem_addr(addr),
        .mem_wdata(wdata), .mem_rdata(rdata_v[0]), .mem_ready(ready_v[0]), .busy(busy_v[0])
`ifdef RAM_WAIT_CTRL_STATS_EN
        , .rd_count(rd_cnt_v[0]), .wr_count(wr_cnt_v[0])
`endif
    );

    ram_wait_ctrl #(.WAIT_CYCLES(0), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_w0 (
        .clk(clk), .rst(rst), .mem_req(req_v[1]), .mem_rw(rw), .mem_addr(addr),
        .mem_wdata(wdata), .mem_rdata(rdata_v[1]), .mem_ready(ready_v[1]), .busy(busy_v[1])
`ifdef RAM_WAIT_CTRL_STATS_EN
        , .rd_count(rd_cnt_v[1]), .wr_count(wr_cnt_v[1])
`endif
    );

    ram_wait_ctrl #(.WAIT_CYCLES(15), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_w15 (
        .clk(clk), .rst(rst), .mem_req(req_v[2]), .mem_rw(rw), .mem_addr(addr),
        .mem_wdata(wdata), .mem_rdata(rdata_v[2]), .mem_ready(ready_v[2]), .busy(busy_v[2])
`ifdef RAM_WAIT_CTRL_STATS_EN
        , .rd_count(rd_cnt_v[2]), .wr_count(wr_cnt_v[2])
`endif
    );

    function automatic int wait_of(input int d);
        case (d)
            0:       return 2;
            1:       return 0;
            default: return 15;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Completion of one access as the model sees it: memory or read register updated, counters bumped.
    task automatic model_complete(input int d, input bit is_wr, input logic [ADDR_W-1:0] a,
                                  input logic [DATA_W-1:0] wd);
        if (is_wr) begin
            model_mem[d][a]   = wd;
            model_valid[d][a] = 1'b1;
            if (model_wrc[d] < 65535) model_wrc[d]++;
        end else begin
            model_rd[d] = model_mem[d][a];
            if (model_rdc[d] < 65535) model_rdc[d]++;
        end
    endtask

    task automatic check_stats(input int d);
`ifdef RAM_WAIT_CTRL_STATS_EN
        check_output($sformatf("rd_count d%0d", d), 32'(rd_cnt_v[d]), 32'(model_rdc[d]));
        check_output($sformatf("wr_count d%0d", d), 32'(wr_cnt_v[d]), 32'(model_wrc[d]));
`endif
    endtask

    // One transaction on instance d; ready must appear exactly WAIT_CYCLES+2 cycles after acceptance.
    task automatic apply_stimulus(input int d, input bit is_wr, input logic [ADDR_W-1:0] a,
                                  input logic [DATA_W-1:0] wd, input bit scramble);
        int w;
        w = wait_of(d);
        @(negedge clk);
        req_v[d] = 1'b1;
        rw       = is_wr;
        addr     = a;
        wdata    = wd;
        for (int cyc = 1; cyc <= w + 3; cyc++) begin
            @(negedge clk);
            if (cyc == w + 2) model_complete(d, is_wr, a, wd);
            check_output($sformatf("ready d%0d c%0d", d, cyc), 32'(ready_v[d]), 32'(cyc == w + 2));
            check_output($sformatf("busy d%0d c%0d", d, cyc), 32'(busy_v[d]), 32'(cyc <= w + 2));
            check_output($sformatf("rdata d%0d c%0d", d, cyc), 32'(rdata_v[d]), 32'(model_rd[d]));
            if (scramble && cyc <= w + 1) begin
                req_v[d] = 1'($urandom);
                rw       = 1'($urandom);
                addr     = ADDR_W'($urandom);
                wdata    = DATA_W'($urandom);
            end else begin
                req_v[d] = 1'b0;
            end
        end
        check_stats(d);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            model_rd[d]  = '0;
            model_rdc[d] = 0;
            model_wrc[d] = 0;
        end
    endtask

    task automatic check_idle_all(input string tag);
        for (int d = 0; d < 3; d++) begin
            check_output($sformatf("%s ready d%0d", tag, d), 32'(ready_v[d]), 32'd0);
            check_output($sformatf("%s busy d%0d", tag, d), 32'(busy_v[d]), 32'd0);
            check_output($sformatf("%s rdata d%0d", tag, d), 32'(rdata_v[d]), 32'(model_rd[d]));
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;
        bit                rwr;
        int                rd;

        rst   = 1'b1;
        rw    = 1'b0;
        addr  = '0;
        wdata = '0;
        for (int d = 0; d < 3; d++) req_v[d] = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_idle_all("reset");
        rst = 1'b0;

        apply_stimulus(0, 1'b1, 10'd83, 10'd300, 1'b0);
        apply_stimulus(0, 1'b0, 10'd83, 10'd0, 1'b1);
        repeat (3) @(negedge clk);
        check_output("rdata hold", 32'(rdata_v[0]), 32'd300);

        apply_stimulus(0, 1'b1, 10'd50, 10'd111, 1'b0);
        apply_stimulus(0, 1'b1, 10'd51, 10'd222, 1'b0);

        // Held request: second read is accepted in the idle cycle after DONE with the address shown then.
        @(negedge clk);
        req_v[0] = 1'b1;
        rw       = 1'b0;
        addr     = 10'd50;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            @(negedge clk);
            if (cyc == 4) model_complete(0, 1'b0, 10'd50, '0);
            if (cyc == 9) model_complete(0, 1'b0, 10'd51, '0);
            check_output($sformatf("b2b ready c%0d", cyc), 32'(ready_v[0]), 32'(cyc == 4 || cyc == 9));
            check_output($sformatf("b2b busy c%0d", cyc), 32'(busy_v[0]), 32'(cyc != 5 && cyc <= 9));
            check_output($sformatf("b2b rdata c%0d", cyc), 32'(rdata_v[0]), 32'(model_rd[0]));
            if (cyc <= 3) addr = ADDR_W'($urandom);
            if (cyc == 4) addr = 10'd51;
            if (cyc == 6) req_v[0] = 1'b0;
        end
        check_output("b2b last", 32'(rdata_v[0]), 32'd222);

        apply_stimulus(1, 1'b1, 10'd5, 10'd9, 1'b0);
        apply_stimulus(1, 1'b0, 10'd5, 10'd0, 1'b0);
        apply_stimulus(2, 1'b1, 10'd1023, 10'd777, 1'b1);
        apply_stimulus(2, 1'b0, 10'd1023, 10'd0, 1'b0);

        // Reset in the middle of a write must leave the old contents in place.
        apply_stimulus(0, 1'b1, 10'd7, 10'd123, 1'b0);
        @(negedge clk);
        req_v[0] = 1'b1;
        rw       = 1'b1;
        addr     = 10'd7;
        wdata    = 10'd555;
        @(negedge clk);
        req_v[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_idle_all("midrst");
        @(negedge clk);
        rst = 1'b0;
        check_stats(0);
        apply_stimulus(0, 1'b0, 10'd7, 10'd0, 1'b1);
        check_output("midrst old", 32'(rdata_v[0]), 32'd123);

        for (int n = 0; n < 40; n++) begin
            rd  = int'($urandom_range(0, 2));
            ra  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
            rwr = model_valid[rd][ra] ? 1'($urandom) : 1'b1;
            apply_stimulus(rd, rwr, ra, DATA_W'($urandom), 1'($urandom));
        end

`ifdef RAM_WAIT_CTRL_STATS_EN
        @(negedge clk);
        u_w2.rd_count_q = 16'hFFFF;
        model_rdc[0]    = 65535;
        apply_stimulus(0, 1'b0, 10'd83, 10'd0, 1'b0);
        check_output("rd_count sat", 32'(rd_cnt_v[0]), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
